// File: rtl/cond_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_exec_unit_pkg
// Shared CPU definitions used by the E-stage conditional execution logic:
//   - NZCV bit indices inside a 4-bit flag vector ordered {N,Z,C,V}
//   - ARM-style condition codes (COND_AL = 4'hE is the "always" bubble cond)
//   - FlagWrite field width and its per-group enable bit positions
//   - packed E-stage control payload and the flag merge helper
// ---------------------------------------------------------------------------
package cond_exec_unit_pkg;

  localparam int unsigned FLAGS_W     = 4;
  localparam int unsigned COND_W      = 4;
  localparam int unsigned FLAGWRITE_W = 2;

  // NZCV bit positions
  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  // FlagWrite enable bits: bit1 covers NZ, bit0 covers CV
  localparam int unsigned FW_NZ_BIT = 1;
  localparam int unsigned FW_CV_BIT = 0;

  // Condition codes
  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;

  // E-stage control payload (one register group)
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic branch;
    logic pc_src;
  } e_ctrl_t;

  localparam int unsigned CTRL_W = $bits(e_ctrl_t);

  localparam e_ctrl_t                CTRL_BUBBLE = '0;
  localparam logic [FLAGWRITE_W-1:0] FW_BUBBLE   = '0;

  // Merge new ALU flags into the current flags, one group per enable bit
  function automatic logic [FLAGS_W-1:0] merge_flags(
    input logic [FLAGS_W-1:0] cur,
    input logic [FLAGS_W-1:0] alu,
    input logic               nz_we,
    input logic               cv_we
  );
    logic [FLAGS_W-1:0] res;
    res = cur;
    if (nz_we) begin
      res[N_IDX] = alu[N_IDX];
      res[Z_IDX] = alu[Z_IDX];
    end
    if (cv_we) begin
      res[C_IDX] = alu[C_IDX];
      res[V_IDX] = alu[V_IDX];
    end
    return res;
  endfunction

endpackage

// File: rtl/cond_exec_unit_flopenrc_e.sv
// ---------------------------------------------------------------------------
// flopenrc_e
// One E-stage pipeline register group: asynchronous reset and synchronous
// clear both load BUBBLE; clear has priority over a held (disabled) enable.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, loads BUBBLE
//   en     - capture enable (deasserted while the stage is stalled)
//   clr    - synchronous clear, loads BUBBLE regardless of en
//   d / q  - WIDTH-bit data in / registered data out
// ---------------------------------------------------------------------------
module flopenrc_e #(
  parameter int unsigned       WIDTH  = 1,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Clear beats enable so a flush wins over a stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= BUBBLE;
    end else if (clr) begin
      r_q <= BUBBLE;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/cond_exec_unit.sv
// ---------------------------------------------------------------------------
// cond_exec_unit
// E-stage conditional execution: captures D-stage controls into E, gates
// them with the external condition-check result, and owns the architectural
// NZCV flag register.
// Optional feature macro: STICKY_Q_EN adds a sticky overflow output StickyQ.
// Ports:
//   clk, reset            - clock / asynchronous active-high reset
//   StallE, FlushE        - E-stage hold / bubble insert (flush wins)
//   CondD, FlagWriteD     - D-stage condition field and flag write enables
//   RegWriteD, MemWriteD,
//   BranchD, PCSrcD       - D-stage controls
//   ALUFlags              - E-stage ALU result flags {N,Z,C,V}
//   CondEx                - condition-met result from the external checker
//   CondE, FlagsE         - registered condition and current flags to checker
//   RegWriteGE, MemWriteGE,
//   PCSrcGE, BranchTakenE - E-stage controls gated by CondEx (combinational)
//   StickyQ               - sticky V flag (only with STICKY_Q_EN)
// ---------------------------------------------------------------------------
module cond_exec_unit
  import cond_exec_unit_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] CondD,
  input  logic [1:0] FlagWriteD,
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic [3:0] ALUFlags,
  input  logic       CondEx,
  output logic [3:0] CondE,
  output logic [3:0] FlagsE,
  output logic       RegWriteGE,
  output logic       MemWriteGE,
  output logic       PCSrcGE,
  output logic       BranchTakenE
`ifdef STICKY_Q_EN
  ,
  output logic       StickyQ
`endif
);

  logic                   w_en;
  e_ctrl_t                w_ctrl_d;
  e_ctrl_t                w_ctrl_e;
  logic [FLAGWRITE_W-1:0] w_fw_e;
  logic [COND_W-1:0]      w_cond_e;
  logic                   w_nz_we;
  logic                   w_cv_we;
  logic [FLAGS_W-1:0]     r_flags;

  assign w_en = ~StallE;

  assign w_ctrl_d = '{
    reg_write: RegWriteD,
    mem_write: MemWriteD,
    branch:    BranchD,
    pc_src:    PCSrcD
  };

  // Condition group: bubble carries AL so the checker always reports met
  flopenrc_e #(
    .WIDTH  (COND_W),
    .BUBBLE (COND_AL)
  ) u_cond_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (FlushE),
    .d     (CondD),
    .q     (w_cond_e)
  );

  // Flag-write group
  flopenrc_e #(
    .WIDTH  (FLAGWRITE_W),
    .BUBBLE (FW_BUBBLE)
  ) u_fw_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (FlushE),
    .d     (FlagWriteD),
    .q     (w_fw_e)
  );

  // Control group
  flopenrc_e #(
    .WIDTH  (CTRL_W),
    .BUBBLE (CTRL_BUBBLE)
  ) u_ctrl_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (FlushE),
    .d     (w_ctrl_d),
    .q     (w_ctrl_e)
  );

  // Flag commit qualifiers; FlushE deliberately absent so a flush does not
  // cancel the write of the instruction already in E
  assign w_nz_we = w_fw_e[FW_NZ_BIT] & CondEx & ~StallE;
  assign w_cv_we = w_fw_e[FW_CV_BIT] & CondEx & ~StallE;

  // Architectural NZCV register; new flags are seen one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= FLAGS_RST;
    end else begin
      r_flags <= merge_flags(r_flags, ALUFlags, w_nz_we, w_cv_we);
    end
  end

`ifdef STICKY_Q_EN
  logic r_sticky_q;

  // Set on any committed CV write with V=1; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky_q <= 1'b0;
    end else if (w_cv_we & ALUFlags[V_IDX]) begin
      r_sticky_q <= 1'b1;
    end
  end

  assign StickyQ = r_sticky_q;
`endif

  assign CondE  = w_cond_e;
  assign FlagsE = r_flags;

  // Reset forces the E controls to bubble, so these read 0 during reset
  assign RegWriteGE   = w_ctrl_e.reg_write & CondEx;
  assign MemWriteGE   = w_ctrl_e.mem_write & CondEx;
  assign PCSrcGE      = w_ctrl_e.pc_src    & CondEx;
  assign BranchTakenE = w_ctrl_e.branch    & CondEx;

endmodule

// File: tb/tb_cond_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_exec_unit
// Self-checking bench for cond_exec_unit. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, well before the next
// rising edge. A behavioural model tracks the E-stage instruction and flags.
// ---------------------------------------------------------------------------
module tb_cond_exec_unit;

  logic       clk;
  logic       reset;
  logic       StallE;
  logic       FlushE;
  logic [3:0] CondD;
  logic [1:0] FlagWriteD;
  logic       RegWriteD;
  logic       MemWriteD;
  logic       BranchD;
  logic       PCSrcD;
  logic [3:0] ALUFlags;
  logic       CondEx;
  logic [3:0] CondE;
  logic [3:0] FlagsE;
  logic       RegWriteGE;
  logic       MemWriteGE;
  logic       PCSrcGE;
  logic       BranchTakenE;
`ifdef STICKY_Q_EN
  logic       StickyQ;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model of the instruction sitting in E plus architectural state
  logic [3:0] m_cond;
  logic [1:0] m_fw;
  logic       m_rw, m_mw, m_br, m_pc;
  logic [3:0] m_flags;
  logic       m_sticky;

  cond_exec_unit #(.FLAGS_RST(4'b0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .CondD        (CondD),
    .FlagWriteD   (FlagWriteD),
    .RegWriteD    (RegWriteD),
    .MemWriteD    (MemWriteD),
    .BranchD      (BranchD),
    .PCSrcD       (PCSrcD),
    .ALUFlags     (ALUFlags),
    .CondEx       (CondEx),
    .CondE        (CondE),
    .FlagsE       (FlagsE),
    .RegWriteGE   (RegWriteGE),
    .MemWriteGE   (MemWriteGE),
    .PCSrcGE      (PCSrcGE),
    .BranchTakenE (BranchTakenE)
`ifdef STICKY_Q_EN
    ,
    .StickyQ      (StickyQ)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ARM condition evaluation from {N,Z,C,V}
  function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_cond   = 4'hE;
    m_fw     = 2'b00;
    {m_rw, m_mw, m_br, m_pc} = 4'b0000;
    m_flags  = 4'b0000;
    m_sticky = 1'b0;
  endtask

  task automatic set_d(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] ctl);
    CondD      = c;
    FlagWriteD = fw;
    {RegWriteD, MemWriteD, BranchD, PCSrcD} = ctl;
  endtask

  // Advance one clock; the model applies the rules using the inputs held
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (m_fw[1] && CondEx && !StallE) m_flags[3:2] = ALUFlags[3:2];
      if (m_fw[0] && CondEx && !StallE) begin
        m_flags[1:0] = ALUFlags[1:0];
        if (ALUFlags[0]) m_sticky = 1'b1;
      end
      if (FlushE) begin
        m_cond = 4'hE; m_fw = 2'b00; {m_rw, m_mw, m_br, m_pc} = 4'b0000;
      end else if (!StallE) begin
        m_cond = CondD; m_fw = FlagWriteD;
        {m_rw, m_mw, m_br, m_pc} = {RegWriteD, MemWriteD, BranchD, PCSrcD};
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'hF;
    set_d(4'h3, 2'b11, 4'b1111);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (FlagsE !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags got %h want 0", FlagsE);
    end
    n_checks++;
    if (CondE !== 4'hE) begin
      n_errors++; $display("FAIL reset_cond got %h want e", CondE);
    end
    n_checks++;
    if ({RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_gated got %b want 0000", {RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE});
    end
    reset = 1'b0;
    // first edge after release captures D
    set_d(4'h6, 2'b00, 4'b1010);
    CondEx = 1;
    tick();
    #1;
    n_checks++;
    if (CondE !== 4'h6 || RegWriteGE !== 1'b1 || BranchTakenE !== 1'b1) begin
      n_errors++; $display("FAIL resume_capture got cond %h rw %b bt %b want 6 1 1", CondE, RegWriteGE, BranchTakenE);
    end
  endtask

  task automatic test_full_flag_write();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'b0110;
    set_d(4'hE, 2'b11, 4'b0000);
    tick();
    set_d(4'hE, 2'b00, 4'b0000);
    #1;
    n_checks++;
    if (FlagsE !== 4'b0000) begin
      n_errors++; $display("FAIL nzcv_no_bypass got %b want 0000", FlagsE);
    end
    tick();
    #1;
    n_checks++;
    if (FlagsE !== 4'b0110) begin
      n_errors++; $display("FAIL nzcv_write got %b want 0110", FlagsE);
    end
  endtask

  task automatic test_nz_only();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'b1111;
    set_d(4'hE, 2'b10, 4'b0000);
    tick();
    set_d(4'hE, 2'b00, 4'b0000);
    tick();
    #1;
    n_checks++;
    if (FlagsE !== 4'b1100) begin
      n_errors++; $display("FAIL nz_only got %b want 1100", FlagsE);
    end
  endtask

  task automatic test_cond_fail();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 0; ALUFlags = 4'b1011;
    set_d(4'h1, 2'b11, 4'b1100);
    tick();
    set_d(4'hE, 2'b00, 4'b0000);
    #1;
    n_checks++;
    if (RegWriteGE !== 1'b0 || MemWriteGE !== 1'b0) begin
      n_errors++; $display("FAIL cond_fail_gate got rw %b mw %b want 0 0", RegWriteGE, MemWriteGE);
    end
    CondEx = 1;
    #1;
    n_checks++;
    if (RegWriteGE !== 1'b1 || MemWriteGE !== 1'b1) begin
      n_errors++; $display("FAIL cond_pass_gate got rw %b mw %b want 1 1", RegWriteGE, MemWriteGE);
    end
    CondEx = 0;
    tick();
    #1;
    n_checks++;
    if (FlagsE !== 4'b0000) begin
      n_errors++; $display("FAIL cond_fail_flags got %b want 0000", FlagsE);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'b0101;
    set_d(4'h9, 2'b11, 4'b1111);
    tick();
    StallE = 1; ALUFlags = 4'b1010;
    set_d(4'h2, 2'b00, 4'b0000);
    tick();
    #1;
    n_checks++;
    if (CondE !== 4'h9 || FlagsE !== 4'b0000 || RegWriteGE !== 1'b1) begin
      n_errors++; $display("FAIL stall_hold got cond %h flags %b rw %b want 9 0000 1", CondE, FlagsE, RegWriteGE);
    end
    FlushE = 1;
    tick();
    #1;
    n_checks++;
    if (CondE !== 4'hE || FlagsE !== 4'b0000 ||
        {RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE} !== 4'b0000) begin
      n_errors++; $display("FAIL stall_flush_bubble got cond %h flags %b want e 0000", CondE, FlagsE);
    end
  endtask

  task automatic test_flush_commits();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'b1001;
    set_d(4'hE, 2'b11, 4'b0100);
    tick();
    FlushE = 1;
    tick();
    FlushE = 0;
    #1;
    n_checks++;
    if (FlagsE !== 4'b1001 || CondE !== 4'hE || MemWriteGE !== 1'b0) begin
      n_errors++; $display("FAIL flush_commit got flags %b cond %h mw %b want 1001 e 0", FlagsE, CondE, MemWriteGE);
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'b1111;
    set_d(4'hE, 2'b11, 4'b0000);
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (FlagsE !== 4'b0000 || CondE !== 4'hE) begin
      n_errors++; $display("FAIL async_reset got flags %b cond %h want 0000 e", FlagsE, CondE);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_d(4'hE, 2'b00, 4'b0000);
    tick();
    #1;
    n_checks++;
    if (FlagsE !== 4'b0000) begin
      n_errors++; $display("FAIL reset_discard got %b want 0000", FlagsE);
    end
  endtask

`ifdef STICKY_Q_EN
  task automatic test_sticky();
    do_reset();
    StallE = 0; FlushE = 0; CondEx = 1; ALUFlags = 4'b0001;
    set_d(4'hE, 2'b01, 4'b0000);
    tick();
    tick();
    n_checks++;
    if (StickyQ !== 1'b1) begin
      n_errors++; $display("FAIL sticky_set got %b want 1", StickyQ);
    end
    for (int i = 0; i < 4; i++) begin
      ALUFlags = 4'($urandom_range(0, 7)) & 4'b1110;
      tick();
    end
    #1;
    n_checks++;
    if (StickyQ !== 1'b1 || FlagsE[0] !== 1'b0) begin
      n_errors++; $display("FAIL sticky_hold got q %b v %b want 1 0", StickyQ, FlagsE[0]);
    end
    do_reset();
    #1;
    n_checks++;
    if (StickyQ !== 1'b0) begin
      n_errors++; $display("FAIL sticky_reset got %b want 0", StickyQ);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      StallE   = ($urandom_range(0, 4) == 0);
      FlushE   = ($urandom_range(0, 6) == 0);
      ALUFlags = 4'($urandom_range(0, 15));
      set_d(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      CondEx   = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : cond_met(m_cond, m_flags);
      #1;
      n_checks++;
      if (CondE !== m_cond) begin
        n_errors++; $display("FAIL rnd_cond[%0d] got %h want %h", i, CondE, m_cond);
      end
      n_checks++;
      if (FlagsE !== m_flags) begin
        n_errors++; $display("FAIL rnd_flags[%0d] got %b want %b", i, FlagsE, m_flags);
      end
      n_checks++;
      if ({RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE} !==
          ({m_rw, m_mw, m_pc, m_br} & {4{CondEx}})) begin
        n_errors++;
        $display("FAIL rnd_gated[%0d] got %b want %b", i, {RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE},
                 {m_rw, m_mw, m_pc, m_br} & {4{CondEx}});
      end
`ifdef STICKY_Q_EN
      n_checks++;
      if (StickyQ !== m_sticky) begin
        n_errors++; $display("FAIL rnd_sticky[%0d] got %b want %b", i, StickyQ, m_sticky);
      end
`endif
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; StallE = 0; FlushE = 0; CondEx = 0; ALUFlags = 4'h0;
    set_d(4'hE, 2'b00, 4'b0000);
    model_reset();
    @(negedge clk);
    test_reset();
    test_full_flag_write();
    test_nz_only();
    test_cond_fail();
    test_stall_flush();
    test_flush_commits();
    test_midop_reset();
`ifdef STICKY_Q_EN
    test_sticky();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 SHALL have parameter FLAGS_RST, default 4'b0000, giving the NZCV flag register reset value.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port StallE, input, 1: hold the E-stage registers and block the flag update.
REQ-005 SHALL have port FlushE, input, 1: load a bubble into the E-stage registers.
REQ-006 SHALL have port CondD, input, 4: condition field of the D-stage instruction.
REQ-007 SHALL have port FlagWriteD, input, 2: bit1 enables NZ, bit0 enables CV.
REQ-008 SHALL have ports RegWriteD, MemWriteD, BranchD, PCSrcD, each input, 1: D-stage controls.
REQ-009 SHALL have port ALUFlags, input, 4: NZCV result of the E-stage ALU, ordered {N,Z,C,V}.
REQ-010 SHALL have port CondEx, input, 1: condition-met result returned by the external condition checker.
REQ-011 SHALL have port CondE, output, 4: registered condition, driven to the checker.
REQ-012 SHALL have port FlagsE, output, 4: current architectural NZCV, driven to the checker.
REQ-013 SHALL have ports RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE, each output, 1: E-stage controls gated by CondEx.

Function
REQ-014 SHALL register CondD, FlagWriteD, RegWriteD, MemWriteD, BranchD and PCSrcD into E-stage registers on each rising edge when StallE=0 and FlushE=0, giving a latency of 1 cycle from D to E.
REQ-015 SHALL hold all E-stage registers when StallE=1 and FlushE=0.
REQ-016 SHALL load a bubble on FlushE=1, with priority over StallE: all E controls 0, FlagWriteE=2'b00, CondE=4'hE.
REQ-017 SHALL drive the gated outputs combinationally:
- RegWriteGE = RegWriteE & CondEx
- MemWriteGE = MemWriteE & CondEx
- PCSrcGE = PCSrcE & CondEx
- BranchTakenE = BranchE & CondEx
REQ-018 SHALL update FlagsE[3:2] from ALUFlags[3:2] at the rising edge only when FlagWriteE[1] & CondEx & ~StallE.
REQ-019 SHALL update FlagsE[1:0] from ALUFlags[1:0] under the same rule, using FlagWriteE[0].
REQ-020 SHALL NOT let FlushE affect FlagsE: a flush in the same cycle as a qualifying flag write still commits the write of the instruction currently in E.
REQ-021 SHALL present the updated flags to the E-stage instruction of the next cycle, with no bypass.
REQ-022 SHALL NOT contain any combinational path from CondEx back to CondE or FlagsE.

Reset
REQ-023 SHALL on reset asynchronously set FlagsE to FLAGS_RST and the E-stage registers to the bubble state of REQ-016.
REQ-024 SHALL hold all gated outputs at 0 while reset is high.
REQ-025 SHALL, when reset is asserted mid-operation, discard any pending flag write.
REQ-026 SHALL resume normal capture on the first rising edge after reset is released.

Configuration
REQ-027 SHALL, with STICKY_Q_EN defined:
- add output StickyQ, 1 bit, reset 0
- set StickyQ on any committed CV write (REQ-019) with ALUFlags[0]=1
- clear StickyQ only by reset
REQ-028 SHALL, without STICKY_Q_EN, have no StickyQ port and no associated state.

Structure
REQ-029 SHALL take the following from the shared cpu package:
- NZCV bit-index constants
- the condition code constants, including COND_AL=4'hE
- the FlagWrite field width
REQ-030 SHALL implement the E-stage control register with synchronous flush/stall and asynchronous reset as one sub-module, flopenrc_e, instantiated once per control group.

Verification
REQ-031 Bench SHALL check: reset with FLAGS_RST=4'b0000 -> FlagsE=0000, CondE=E, all gated outputs 0.
REQ-032 Bench SHALL check: CondD=E, FlagWriteD=11, ALUFlags=0110, CondEx=1 -> FlagsE=0110 one edge after the instruction enters E.
REQ-033 Bench SHALL check: FlagWriteE=10, CondEx=1, ALUFlags=1111 with FlagsE=0000 -> FlagsE=1100, with CV unchanged.
REQ-034 Bench SHALL check: RegWriteE=1, MemWriteE=1, CondEx=0 -> RegWriteGE=0, MemWriteGE=0, and FlagsE unchanged despite FlagWriteE=11.
REQ-035 Bench SHALL check: StallE=1 with FlagWriteE=11, CondEx=1 -> E registers and FlagsE held; FlushE=1 and StallE=1 together -> bubble loaded, CondE=E.
REQ-036 Bench SHALL check, with STICKY_Q_EN defined: a committed CV write with ALUFlags=0001, followed by writes with V=0 -> StickyQ stays 1 until reset.
